phase_acc_bank: RTL and testbench

Time-multiplexed phase accumulator for all synth voices, sitting directly downstream of the note-to-frequency constant ROM stage. Once per audio sample it sweeps every voice: it drives the voice's 9-bit note index to the ROM and receives the 24-bit phase increment one clock later. It then adds that increment into the voice's 32-bit phase register and streams the updated phase to the oscillator/wavetable stage. It also holds the per-voice note table written by the voice allocator.

---
 rtl/phase_acc_bank.sv | 180 ++++++++++++++++++
 tb/tb_phase_acc_bank.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_acc_bank.sv
`default_nettype none
// ============================================================================
// Module   : phase_acc_bank
// Purpose  : Time-multiplexed 32-bit phase accumulator for all synth voices.
//            Each sample_tick sweeps every voice: the voice's note index goes
//            to the ROM stage on sound_out, the phase increment comes back on
//            constant_in one clock later, and the updated phase is streamed
//            out on phase_out/phase_voice/phase_valid. Also holds the
//            per-voice note table (sound, gate, pending retrigger).
// Ports    : clk, reset_reg_N (async, active-low)
//            sample_tick              - start one sweep
//            note_wr/voice/sound/gate/retrig - note table write port
//            sound_out                - note index to ROM stage (registered)
//            constant_in              - phase increment from ROM (1-cycle lat.)
//            phase_out/phase_voice/phase_valid - updated phase stream
//            busy, overrun            - sweep status / dropped tick pulse
// Revision : 1.0 - initial release
// ============================================================================
module phase_acc_bank #(
    parameter  int VOICES  = 8,
    parameter  int PHASE_W = 32,
    parameter  int CONST_W = 24,
    localparam int VW      = $clog2(VOICES)
) (
    input  logic               clk,
    input  logic               reset_reg_N,
    input  logic               sample_tick,
    input  logic               note_wr,
    input  logic [VW-1:0]      note_voice,
    input  logic [8:0]         note_sound,
    input  logic               note_gate,
    input  logic               note_retrig,
    output logic [8:0]         sound_out,
    input  logic [CONST_W-1:0] constant_in,
    output logic [PHASE_W-1:0] phase_out,
    output logic [VW-1:0]      phase_voice,
    output logic               phase_valid,
    output logic               busy,
    output logic               overrun
);

    localparam logic [1:0]    c_ST_IDLE    = 2'd0;
    localparam logic [1:0]    c_ST_SWEEP   = 2'd1;
    localparam logic [1:0]    c_ST_DRAIN   = 2'd2;
    localparam logic [VW-1:0] c_LAST_VOICE = VW'(VOICES - 1);
    // Drain lasts until the last voice's phase has been presented, so busy
    // covers every phase_valid cycle of the sweep.
    localparam logic [1:0]    c_DRAIN_LAST = 2'd2;

    logic [1:0]         r_state;
    logic [VW-1:0]      r_issue_cnt;
    logic [1:0]         r_drain_cnt;

    // Voice tag pipeline: stage 1 aligns with sound_out, stage 2 with
    // constant_in coming back from the ROM.
    logic               r_p1_valid;
    logic [VW-1:0]      r_p1_voice;
    logic               r_p2_valid;
    logic [VW-1:0]      r_p2_voice;

    logic [8:0]         r_sound [VOICES];
    logic [VOICES-1:0]  r_gate;
    logic [VOICES-1:0]  r_retrig_pend;
    logic [PHASE_W-1:0] r_phase [VOICES];

    logic               w_issue;
    logic               w_acc_hit;
    logic               w_wr_retrig_hit;
    logic [PHASE_W-1:0] w_new_phase;

    // Voice 0 is issued on the very edge that accepts the tick, so the
    // counter sits at 0 whenever the FSM is idle.
    assign w_issue = ((r_state == c_ST_IDLE) && sample_tick) ||
                     (r_state == c_ST_SWEEP);

    // ------------------------------------------------------------------
    // Sweep control and issue to ROM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_state     <= c_ST_IDLE;
            r_issue_cnt <= '0;
            r_drain_cnt <= '0;
            r_p1_valid  <= 1'b0;
            r_p1_voice  <= '0;
            sound_out   <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun    <= sample_tick && (r_state != c_ST_IDLE);
            r_p1_valid <= w_issue;
            if (w_issue) begin
                sound_out  <= r_sound[r_issue_cnt];
                r_p1_voice <= r_issue_cnt;
                busy       <= 1'b1;
                if (r_issue_cnt == c_LAST_VOICE) begin
                    r_state     <= c_ST_DRAIN;
                    r_issue_cnt <= '0;
                    r_drain_cnt <= '0;
                end else begin
                    r_state     <= c_ST_SWEEP;
                    r_issue_cnt <= r_issue_cnt + 1'b1;
                end
            end else if (r_state == c_ST_DRAIN) begin
                if (r_drain_cnt == c_DRAIN_LAST) begin
                    r_state <= c_ST_IDLE;
                    busy    <= 1'b0;
                end else begin
                    r_drain_cnt <= r_drain_cnt + 2'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulate stage
    // ------------------------------------------------------------------
    // A retrigger written in the same cycle the voice accumulates takes
    // effect immediately instead of being parked as a pending flag.
    assign w_acc_hit       = r_p2_valid && note_wr && (note_voice == r_p2_voice);
    assign w_wr_retrig_hit = w_acc_hit && note_retrig;

    always_comb begin
        w_new_phase = r_phase[r_p2_voice];
        if (r_retrig_pend[r_p2_voice] || w_wr_retrig_hit) begin
            w_new_phase = '0;
        end else if (r_gate[r_p2_voice]) begin
            w_new_phase = r_phase[r_p2_voice] + PHASE_W'(constant_in);
        end
    end

    always_ff @(posedge clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_p2_valid  <= 1'b0;
            r_p2_voice  <= '0;
            phase_valid <= 1'b0;
            phase_out   <= '0;
            phase_voice <= '0;
            for (int i = 0; i < VOICES; i++) begin
                r_phase[i] <= '0;
            end
        end else begin
            r_p2_valid  <= r_p1_valid;
            r_p2_voice  <= r_p1_voice;
            phase_valid <= r_p2_valid;
            if (r_p2_valid) begin
                r_phase[r_p2_voice] <= w_new_phase;
                phase_out           <= w_new_phase;
                phase_voice         <= r_p2_voice;
            end
        end
    end

    // ------------------------------------------------------------------
    // Note table
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_gate        <= '0;
            r_retrig_pend <= '0;
            for (int i = 0; i < VOICES; i++) begin
                r_sound[i] <= '0;
            end
        end else begin
            // The accumulating voice consumes its pending retrigger.
            if (r_p2_valid) begin
                r_retrig_pend[r_p2_voice] <= 1'b0;
            end
            if (note_wr) begin
                r_sound[note_voice] <= note_sound;
                r_gate[note_voice]  <= note_gate;
                if (note_retrig && !w_acc_hit) begin
                    r_retrig_pend[note_voice] <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phase_acc_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_acc_bank
// Purpose  : Directed self-checking bench for phase_acc_bank with a
//            registered ROM model returning sound*1000 (or 0xFFFFFF).
// Revision : 1.0 - initial release
// ============================================================================
module tb_phase_acc_bank;

    localparam int VOICES = 8;
    localparam int VW     = 3;

    logic        clk = 1'b0;
    logic        reset_reg_N;
    logic        sample_tick;
    logic        note_wr;
    logic [VW-1:0] note_voice;
    logic [8:0]  note_sound;
    logic        note_gate;
    logic        note_retrig;
    logic [8:0]  sound_out;
    logic [23:0] constant_in;
    logic [31:0] phase_out;
    logic [VW-1:0] phase_voice;
    logic        phase_valid;
    logic        busy;
    logic        overrun;

    phase_acc_bank #(.VOICES(VOICES), .PHASE_W(32), .CONST_W(24)) dut (
        .clk         (clk),
        .reset_reg_N (reset_reg_N),
        .sample_tick (sample_tick),
        .note_wr     (note_wr),
        .note_voice  (note_voice),
        .note_sound  (note_sound),
        .note_gate   (note_gate),
        .note_retrig (note_retrig),
        .sound_out   (sound_out),
        .constant_in (constant_in),
        .phase_out   (phase_out),
        .phase_voice (phase_voice),
        .phase_valid (phase_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // ROM model: one registered cycle of latency.
    logic rom_max = 1'b0;
    always @(posedge clk) begin
        constant_in <= rom_max ? 24'hFFFFFF : 24'(int'(sound_out) * 1000);
    end

    typedef struct {
        int          voice;
        logic [31:0] phase;
        int          cyc;
    } rec_t;

    rec_t        recs[$];
    int          cyc      = 0;
    int          tick_cyc = -100;
    int          busy_cnt = 0;
    int          ovr_cnt  = 0;
    logic [8:0]  so_t4    = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (phase_valid) recs.push_back('{int'(phase_voice), phase_out, cyc});
        if (busy) busy_cnt++;
        if (overrun) ovr_cnt++;
        if (cyc == tick_cyc + 3) so_t4 = sound_out;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Phase reported for voice v in the captured records (sentinel if absent).
    task automatic check_voice(input string tag, input int v, input logic [63:0] exp);
        logic [63:0] got = 64'hBAD0_0000_0000_0000;
        foreach (recs[i]) if (recs[i].voice == v) got = 64'(recs[i].phase);
        check(tag, got, exp);
    endtask

    // Called at a falling edge: tick is sampled on the next rising edge.
    task automatic do_tick(input int n);
        sample_tick = 1'b1;
        tick_cyc    = cyc + 1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_note(input int v, input int s, input logic g, input logic r);
        note_wr     = 1'b1;
        note_voice  = VW'(v);
        note_sound  = 9'(s);
        note_gate   = g;
        note_retrig = r;
        @(negedge clk);
        note_wr     = 1'b0;
        note_retrig = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint wrap_full;
        reset_reg_N = 1'b0;
        sample_tick = 1'b0;
        note_wr     = 1'b0;
        note_voice  = '0;
        note_sound  = '0;
        note_gate   = 1'b0;
        note_retrig = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_sound_out",   64'(sound_out),   0);
        check("rst_phase_out",   64'(phase_out),   0);
        check("rst_phase_voice", 64'(phase_voice), 0);
        check("rst_valid_busy_ovr", {61'd0, phase_valid, busy, overrun}, 0);
        reset_reg_N = 1'b1;
        @(negedge clk);

        // Sweep with all gates closed
        recs.delete(); busy_cnt = 0;
        do_tick(12);
        check("t1_count", 64'(recs.size()), 8);
        for (int v = 0; v < VOICES; v++) begin
            if (v < recs.size()) begin
                check($sformatf("t1_voice%0d", v), 64'(recs[v].voice), 64'(v));
                check($sformatf("t1_phase%0d", v), 64'(recs[v].phase), 0);
                check($sformatf("t1_cyc%0d", v), 64'(recs[v].cyc - tick_cyc), 64'(2 + v));
            end
        end
        check("t1_busy_cycles", 64'(busy_cnt), 10);

        // Voice 3: sound 69, constant 69000 per sweep
        wr_note(3, 69, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            recs.delete();
            do_tick(12);
            check_voice($sformatf("t2_v3_sweep%0d", k), 3, 64'(69000 * k));
            check_voice($sformatf("t2_v0_sweep%0d", k), 0, 0);
            if (k == 1) check("t2_sound_out_T4", 64'(so_t4), 69);
        end

        // Retrigger collision on voice 2 (constant 10000)
        wr_note(2, 10, 1'b1, 1'b0);
        recs.delete();
        do_tick(12);
        check_voice("t3_v2_sweepA", 2, 10000);
        check_voice("t3_v3_sweepA", 3, 276000);
        recs.delete();
        sample_tick = 1'b1;
        tick_cyc    = cyc + 1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        wr_note(2, 10, 1'b1, 1'b1);   // sampled on the edge voice 2 accumulates
        repeat (10) @(negedge clk);
        check_voice("t3_v2_collide", 2, 0);
        check_voice("t3_v3_sweepB", 3, 345000);
        recs.delete();
        do_tick(12);
        check_voice("t3_v2_after", 2, 10000);
        check_voice("t3_v3_sweepC", 3, 414000);

        // Tick three cycles after a tick
        recs.delete(); busy_cnt = 0; ovr_cnt = 0;
        sample_tick = 1'b1;
        tick_cyc    = cyc + 1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (14) @(negedge clk);
        check("t4_overrun_cycles", 64'(ovr_cnt), 1);
        check("t4_valid_count", 64'(recs.size()), 8);
        check("t4_busy_cycles", 64'(busy_cnt), 10);
        check_voice("t4_v3", 3, 483000);
        check_voice("t4_v2", 2, 20000);

        // Reset in cycle T+5 of a sweep
        do_tick(4);
        check("t5_valid_before_rst", 64'(phase_valid), 1);
        reset_reg_N = 1'b0;
        #1;
        check("t5_valid_async", 64'(phase_valid), 0);
        check("t5_busy_async", 64'(busy), 0);
        check("t5_sound_out_async", 64'(sound_out), 0);
        repeat (2) @(negedge clk);
        recs.delete();
        reset_reg_N = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_no_valid_after_rst", 64'(recs.size()), 0);
        do_tick(12);
        check("t5_new_sweep_count", 64'(recs.size()), 8);
        check_voice("t5_v3_cleared", 3, 0);

        // Wrap: 1000 sweeps adding 0xFFFFFF to voice 5
        // 16777215000 mod 2^32 = 3892313112
        wr_note(5, 1, 1'b1, 1'b0);
        rom_max = 1'b1;
        ovr_cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            if (k == 999) recs.delete();
            do_tick(10);
        end
        wrap_full = 64'd1000 * 64'd16777215;
        check_voice("t6_wrap_v5", 5, 64'(wrap_full[31:0]));
        check_voice("t6_wrap_v4", 4, 0);
        check("t6_wrap_count", 64'(recs.size()), 8);
        check("t6_no_overrun", 64'(ovr_cnt), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
